impartire: RTL

Sequential IEEE-754 binary32 divider, the inverse companion of the FPU's combinational multiplier. It computes `div32 = a / b` with round-to-nearest-even using a 27-iteration restoring significand divider, and hands off through a start/busy/done handshake. It handles denormal inputs and outputs with the same conventions as the multiplier, and sits beside the multiplier in the FPU datapath.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/impartire_if.sv | 16 +
 rtl/fp_lzc24.sv | 17 +
 rtl/impartire.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 constants, field layout and divider state encoding for the FPU.
package fpu_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned Q_W    = 27;
  localparam int unsigned REM_W  = 25;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LZC_W  = 5;
  localparam int unsigned E_W    = 10;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 128;
  localparam int EXP_MIN = -126;

  localparam logic [FP_W-1:0]  QNAN          = 32'h7FC0_0000;
  localparam logic [CNT_W-1:0] DIV_LAST_STEP = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_ROUND
  } div_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/impartire_if.sv
// Start/busy/done handshake bundle between the FPU sequencer and the divider.
interface impartire_if;
  import fpu_pkg::*;

  logic            start;
  logic [FP_W-1:0] a;
  logic [FP_W-1:0] b;
  logic            busy;
  logic            done;
  logic [FP_W-1:0] div32;
  logic            dz;

  modport master (output start, a, b, input busy, done, div32, dz);
  modport slave  (input start, a, b, output busy, done, div32, dz);

endinterface

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero input.
module fp_lzc24
  import fpu_pkg::*;
(
  input  logic [SIG_W-1:0] in_i,
  output logic [LZC_W-1:0] cnt_o
);

  // Scan upwards so the highest set bit wins.
  always_comb begin
    cnt_o = LZC_W'(SIG_W);
    for (int i = 0; i < int'(SIG_W); i++) begin
      if (in_i[i]) cnt_o = LZC_W'(int'(SIG_W) - 1 - i);
    end
  end

endmodule

// File: rtl/impartire.sv
// Sequential binary32 divider: unpack, 27-step restoring divide, RNE round.
module impartire
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  impartire_if.slave  bus
);

  localparam logic signed [E_W-1:0] EMIN_S = E_W'(EXP_MIN);
  localparam logic signed [E_W-1:0] EMAX_S = E_W'(EXP_MAX);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  fp32_t                  a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [E_W-1:0]  exp_q, exp_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [SIG_W-1:0]       mb_q, mb_d;
  logic [Q_W-1:0]         q_q, q_d;
  logic                   spec_q, spec_d, spec_dz_q, spec_dz_d;
  logic [FP_W-1:0]        spec_res_q, spec_res_d;
  logic                   busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [FP_W-1:0]        div32_q, div32_d;

  logic [LZC_W-1:0]       lzc_a, lzc_b;
  logic [SIG_W-1:0]       sig_a, sig_b;

  assign sig_a = {|a_q.exp, a_q.frac};
  assign sig_b = {|b_q.exp, b_q.frac};

  fp_lzc24 u_lzc_a (.in_i(sig_a), .cnt_o(lzc_a));
  fp_lzc24 u_lzc_b (.in_i(sig_b), .cnt_o(lzc_b));

  // Operand unpacking, denormal normalisation and special-case detection.
  logic signed [E_W-1:0]  ea, eb;
  logic [SIG_W-1:0]       na, nb;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  always_comb begin
    ea = (|a_q.exp) ? ($signed({2'b00, a_q.exp}) - 10'sd127) : -10'sd126;
    eb = (|b_q.exp) ? ($signed({2'b00, b_q.exp}) - 10'sd127) : -10'sd126;
    ea = ea - $signed({5'b00000, lzc_a});
    eb = eb - $signed({5'b00000, lzc_b});
    na = SIG_W'(sig_a << lzc_a);
    nb = SIG_W'(sig_b << lzc_b);
    a_nan  = (&a_q.exp) & (|a_q.frac);
    b_nan  = (&b_q.exp) & (|b_q.frac);
    a_inf  = (&a_q.exp) & ~(|a_q.frac);
    b_inf  = (&b_q.exp) & ~(|b_q.frac);
    a_zero = ~(|a_q.exp) & ~(|a_q.frac);
    b_zero = ~(|b_q.exp) & ~(|b_q.frac);
  end

  // One restoring step: subtract the divisor if it fits, then shift.
  logic [REM_W:0]   diff;
  logic             ge;
  logic [REM_W-1:0] rem_sel;
  always_comb begin
    diff    = {1'b0, rem_q} - {2'b00, mb_q};
    ge      = ~diff[REM_W];
    rem_sel = ge ? diff[REM_W-1:0] : rem_q;
  end

  // Normalise the quotient, denormalise on underflow, round to nearest even.
  logic [SIG_W-1:0]      man24, man_f;
  logic                  rnd, stk, inc, uf_zero;
  logic signed [E_W-1:0] e_n, sh;
  logic [SIG_W:0]        ext, man_r;
  logic [2*SIG_W+1:0]    wide;
  logic [EXP_W-1:0]      field;
  logic [FP_W-1:0]       res_c;
  always_comb begin
    if (q_q[26]) begin
      man24 = q_q[26:3];
      rnd   = q_q[2];
      stk   = (|q_q[1:0]) | (|rem_q);
      e_n   = exp_q;
    end else begin
      man24 = q_q[25:2];
      rnd   = q_q[1];
      stk   = q_q[0] | (|rem_q);
      e_n   = exp_q - 10'sd1;
    end
    ext     = {man24, rnd};
    sh      = '0;
    wide    = '0;
    uf_zero = 1'b0;
    if (e_n < EMIN_S) begin
      sh = EMIN_S - e_n;
      if (sh > 10'sd25) begin
        uf_zero = 1'b1;
      end else begin
        wide = {ext, 25'b0} >> sh[4:0];
        ext  = wide[49:25];
        stk  = stk | (|wide[24:0]);
      end
      e_n = EMIN_S;
    end
    inc   = ext[0] & (stk | ext[1]);
    man_r = {1'b0, ext[SIG_W:1]} + (SIG_W+1)'(inc);
    if (man_r[SIG_W]) begin
      man_f = man_r[SIG_W:1];
      e_n   = e_n + 10'sd1;
    end else begin
      man_f = man_r[SIG_W-1:0];
    end
    field = man_f[SIG_W-1] ? EXP_W'(e_n + 10'sd127) : '0;
    if (uf_zero)             res_c = {sign_q, 31'b0};
    else if (e_n >= EMAX_S)  res_c = {sign_q, 8'hFF, 23'b0};
    else                     res_c = {sign_q, field, man_f[FRAC_W-1:0]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    rem_d      = rem_q;
    mb_d       = mb_q;
    q_d        = q_q;
    spec_d     = spec_q;
    spec_dz_d  = spec_dz_q;
    spec_res_d = spec_res_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    div32_d    = div32_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        busy_d     = 1'b1;
        sign_d     = a_q.sign ^ b_q.sign;
        exp_d      = ea - eb;
        rem_d      = {1'b0, na};
        mb_d       = nb;
        q_d        = '0;
        cnt_d      = '0;
        spec_d     = 1'b1;
        spec_dz_d  = 1'b0;
        spec_res_d = QNAN;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
          spec_res_d = QNAN;
        end else if (b_zero) begin
          spec_res_d = {a_q.sign ^ b_q.sign, 8'hFF, 23'b0};
          spec_dz_d  = 1'b1;
        end else if (a_inf) begin
          spec_res_d = {a_q.sign ^ b_q.sign, 8'hFF, 23'b0};
        end else if (a_zero | b_inf) begin
          spec_res_d = {a_q.sign ^ b_q.sign, 31'b0};
        end else begin
          spec_d = 1'b0;
        end
        state_d = spec_d ? ST_ROUND : ST_DIV;
      end
      ST_DIV: begin
        q_d   = {q_q[Q_W-2:0], ge};
        rem_d = REM_W'(rem_sel << 1);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == DIV_LAST_STEP) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        div32_d = spec_q ? spec_res_q : res_c;
        dz_d    = spec_q & spec_dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      mb_q       <= '0;
      q_q        <= '0;
      spec_q     <= 1'b0;
      spec_dz_q  <= 1'b0;
      spec_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      div32_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      mb_q       <= mb_d;
      q_q        <= q_d;
      spec_q     <= spec_d;
      spec_dz_q  <= spec_dz_d;
      spec_res_q <= spec_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      div32_q    <= div32_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.div32 = div32_q;
  assign bus.dz    = dz_q;

endmodule
